// File: rtl/plaintext_drawer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | plaintext_drawer: renders a latched 128-bit plaintext as 16 8x8 glyphs    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module plaintext_drawer #(
    parameter logic [8:0] X0 = 9'd32,
    parameter logic [7:0] Y0 = 8'd100,
    parameter logic       FG = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         dpt,
    input  logic [127:0] plaintext,
    output logic         ddpt,
    output logic [10:0]  font_addr,
    input  logic [7:0]   font_data,
    output logic         wr_en,
    input  logic         wr_ready,
    output logic [8:0]   wr_x,
    output logic [7:0]   wr_y,
    output logic         wr_color
);

    localparam logic [2:0] C_IDLE  = 3'd0;
    localparam logic [2:0] C_FETCH = 3'd1;
    localparam logic [2:0] C_LOAD  = 3'd2;
    localparam logic [2:0] C_PIXEL = 3'd3;
    localparam logic [2:0] C_DONE  = 3'd4;

    logic [2:0]   state_q, state_d;
    logic [127:0] text_q, text_d;
    logic [3:0]   char_idx_q, char_idx_d;
    logic [2:0]   row_q, row_d;
    logic [2:0]   col_q, col_d;
    logic [7:0]   shift_q, shift_d;
    logic         wr_en_q, wr_en_d;
    logic [8:0]   wr_x_q, wr_x_d;
    logic [7:0]   wr_y_q, wr_y_d;
    logic         wr_color_q, wr_color_d;

    logic         w_xfer;
    logic         w_last_pixel;
    logic [6:0]   w_char_msb;
    logic [7:0]   w_char;

    assign w_xfer       = wr_en_q && wr_ready;
    assign w_last_pixel = (col_q == 3'd7) && (row_q == 3'd7) && (char_idx_q == 4'd15);
    // Character 0 sits in the top byte, so the index counts down from bit 127.
    assign w_char_msb   = 7'd127 - {char_idx_q, 3'b000};
    assign w_char       = text_q[w_char_msb -: 8];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= C_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            C_IDLE:  if (dpt) state_d = C_FETCH;
            C_FETCH: state_d = C_LOAD;
            C_LOAD:  state_d = C_PIXEL;
            C_PIXEL: begin
                if (w_xfer && (col_q == 3'd7)) begin
                    state_d = w_last_pixel ? C_DONE : C_FETCH;
                end
            end
            C_DONE:  if (!dpt) state_d = C_IDLE;
            default: state_d = C_IDLE;
        endcase
    end

    always_comb begin
        ddpt      = (state_q == C_DONE);
        font_addr = (state_q == C_FETCH) ? {w_char, row_q} : 11'd0;
    end

    always_comb begin
        text_d     = text_q;
        char_idx_d = char_idx_q;
        row_d      = row_q;
        col_d      = col_q;
        shift_d    = shift_q;
        wr_en_d    = wr_en_q;
        wr_x_d     = wr_x_q;
        wr_y_d     = wr_y_q;
        wr_color_d = wr_color_q;
        case (state_q)
            C_IDLE: begin
                if (dpt) begin
                    text_d     = plaintext;
                    char_idx_d = 4'd0;
                    row_d      = 3'd0;
                    col_d      = 3'd0;
                end
            end
            C_LOAD: begin
                // The first pixel of the row is registered here so PIXEL starts valid.
                shift_d    = font_data;
                col_d      = 3'd0;
                wr_en_d    = 1'b1;
                wr_x_d     = X0 + {2'b00, char_idx_q, 3'b000};
                wr_y_d     = Y0 + {5'b00000, row_q};
                wr_color_d = font_data[7] ? FG : ~FG;
            end
            C_PIXEL: begin
                if (w_xfer) begin
                    shift_d = {shift_q[6:0], 1'b0};
                    if (col_q != 3'd7) begin
                        col_d      = col_q + 3'd1;
                        wr_x_d     = wr_x_q + 9'd1;
                        wr_color_d = shift_q[6] ? FG : ~FG;
                    end else begin
                        wr_en_d = 1'b0;
                        col_d   = 3'd0;
                        if (row_q != 3'd7) begin
                            row_d = row_q + 3'd1;
                        end else begin
                            row_d      = 3'd0;
                            char_idx_d = char_idx_q + 4'd1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            text_q     <= 128'd0;
            char_idx_q <= 4'd0;
            row_q      <= 3'd0;
            col_q      <= 3'd0;
            shift_q    <= 8'd0;
            wr_en_q    <= 1'b0;
            wr_x_q     <= 9'd0;
            wr_y_q     <= 8'd0;
            wr_color_q <= 1'b0;
        end else begin
            text_q     <= text_d;
            char_idx_q <= char_idx_d;
            row_q      <= row_d;
            col_q      <= col_d;
            shift_q    <= shift_d;
            wr_en_q    <= wr_en_d;
            wr_x_q     <= wr_x_d;
            wr_y_q     <= wr_y_d;
            wr_color_q <= wr_color_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_x     = wr_x_q;
    assign wr_y     = wr_y_q;
    assign wr_color = wr_color_q;

endmodule
`default_nettype wire

// File: tb/tb_plaintext_drawer.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | tb_plaintext_drawer: scoreboard bench with a glyph-level reference model  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_plaintext_drawer;

    localparam int C_X0 = 32;
    localparam int C_Y0 = 100;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         dpt = 1'b0;
    logic [127:0] plaintext = '0;
    logic         ddpt;
    logic [10:0]  font_addr;
    logic [7:0]   font_data = 8'd0;
    logic         wr_en;
    logic         wr_ready = 1'b1;
    logic [8:0]   wr_x;
    logic [7:0]   wr_y;
    logic         wr_color;

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic       c;
    } pix_t;

    pix_t exp_q[$];
    pix_t front;
    int   total = 0;
    int   bad = 0;
    int   writes = 0;
    int   rom_mode = 0;
    int   rdy_mode = 0;
    int   rdy_k = 0;

    always #5 clk = ~clk;

    plaintext_drawer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .dpt       (dpt),
        .plaintext (plaintext),
        .ddpt      (ddpt),
        .font_addr (font_addr),
        .font_data (font_data),
        .wr_en     (wr_en),
        .wr_ready  (wr_ready),
        .wr_x      (wr_x),
        .wr_y      (wr_y),
        .wr_color  (wr_color)
    );

    function automatic logic [7:0] rom_fn(input logic [10:0] a);
        logic [15:0] h;
        if (rom_mode == 0) return 8'hF0;
        h = ({5'b00000, a} * 16'd40503) ^ 16'h5A3C;
        return h[12:5];
    endfunction

    // Synchronous font ROM: data for an address appears one cycle later.
    always @(posedge clk) font_data <= rom_fn(font_addr);

    // rdy_k is the index of the upcoming edge relative to the dpt-sampling edge.
    always @(posedge clk) begin
        #2;
        rdy_k = rdy_k + 1;
        case (rdy_mode)
            0:       wr_ready = 1'b1;
            1:       wr_ready = ((rdy_k % 2) == 0);
            default: wr_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && wr_en) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_write actual x=%0d y=%0d c=%0d required none", wr_x, wr_y, wr_color);
            end else begin
                front = exp_q[0];
                check("pixel{x,y,c}", 32'({wr_x, wr_y, wr_color}), 32'(front));
                if (wr_ready) begin
                    void'(exp_q.pop_front());
                    writes++;
                end
            end
        end
    end

    // Reference model: every pixel of every glyph, character-major, row, column.
    task automatic push_expected(input logic [127:0] txt);
        logic [7:0] ch;
        logic [7:0] glyph;
        pix_t       p;
        for (int c = 0; c < 16; c++) begin
            ch = txt[127 - 8*c -: 8];
            for (int r = 0; r < 8; r++) begin
                glyph = rom_fn({ch, 3'(r)});
                for (int k = 0; k < 8; k++) begin
                    p.x = 9'((C_X0 + 8*c + k) % 512);
                    p.y = 8'((C_Y0 + r) % 256);
                    p.c = glyph[7-k];
                    exp_q.push_back(p);
                end
            end
        end
    endtask

    task automatic run_draw(input logic [127:0] txt, input int rmode, input int exp_edge,
                            input bit chk_fa, input int drop_after, input bit scramble,
                            input bit rel_reset);
        int base;
        int cnt;
        bit done;
        @(posedge clk); #1;
        plaintext = txt;
        push_expected(txt);
        rdy_mode = rmode;
        rdy_k = -1;
        if (rel_reset) reset_n = 1'b1;
        base = writes;
        dpt = 1'b1;
        cnt = 0;
        done = 1'b0;
        while (!done && cnt < 6000) begin
            @(posedge clk); #1;
            if (chk_fa && cnt < 160 && (cnt % 10) == 0)
                check("font_addr", 32'({txt[127 - 8*(cnt/80) -: 8], 3'((cnt/10) % 8)}), 32'(font_addr));
            if (scramble) plaintext = {$urandom, $urandom, $urandom, $urandom};
            if (drop_after > 0 && (writes - base) >= drop_after) dpt = 1'b0;
            if (ddpt) done = 1'b1;
            else cnt++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL ddpt_timeout actual=no ddpt required=ddpt within 6000 cycles");
        end
        // cnt+1 is the edge at which the registered ddpt is first sampled high.
        if (exp_edge > 0) check("ddpt_latency", 32'(cnt + 1), 32'(exp_edge));
        check("write_count", 32'(writes - base), 32'd1024);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] txt;
        int guard;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ddpt", 32'(ddpt), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_x", 32'(wr_x), 32'd0);
        check("rst_wr_y", 32'(wr_y), 32'd0);
        check("rst_wr_color", 32'(wr_color), 32'd0);
        check("rst_font_addr", 32'(font_addr), 32'd0);
        reset_n = 1'b1;

        // All 'A', constant 0xF0 glyph rows, wr_ready tied high.
        rom_mode = 0;
        run_draw({16{8'h41}}, 0, 1281, 1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("ddpt_hold", 32'(ddpt), 32'd1);
        end
        dpt = 1'b0;
        @(posedge clk); #1;
        check("ddpt_drop", 32'(ddpt), 32'd0);
        repeat (3) @(posedge clk);

        // Font address sequence with 'Z',' ' leading; new text latched on re-request.
        rom_mode = 1;
        txt = {8'h5A, 8'h20, 16'($urandom), {$urandom, $urandom, $urandom}};
        run_draw(txt, 0, 1281, 1'b1, 0, 1'b0, 1'b0);
        dpt = 1'b0;
        @(posedge clk); #1;
        check("ddpt_drop2", 32'(ddpt), 32'd0);
        repeat (2) @(posedge clk);

        // Alternating wr_ready, low on the first PIXEL cycle of every row.
        txt = {$urandom, $urandom, $urandom, $urandom};
        run_draw(txt, 1, 2305, 1'b0, 0, 1'b0, 1'b0);
        dpt = 1'b0;
        @(posedge clk); #1;
        check("ddpt_drop3", 32'(ddpt), 32'd0);
        repeat (2) @(posedge clk);

        // dpt dropped mid-draw, random stalls, plaintext churning after the latch.
        txt = {$urandom, $urandom, $urandom, $urandom};
        run_draw(txt, 2, 0, 1'b0, 200, 1'b1, 1'b0);
        @(posedge clk); #1;
        check("ddpt_one_cycle", 32'(ddpt), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("idle_no_write", 32'(wr_en), 32'd0);

        // Asynchronous reset after 500 writes, then a fresh draw from the origin.
        @(posedge clk); #1;
        txt = {$urandom, $urandom, $urandom, $urandom};
        plaintext = txt;
        push_expected(txt);
        rdy_mode = 0;
        guard = writes;
        dpt = 1'b1;
        for (int i = 0; i < 2000 && (writes - guard) < 500; i++) @(posedge clk);
        check("pre_reset_writes", 32'((writes - guard) >= 500), 32'd1);
        @(negedge clk); #2;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("async_rst_wr_en", 32'(wr_en), 32'd0);
        check("async_rst_ddpt", 32'(ddpt), 32'd0);
        check("async_rst_wr_x", 32'(wr_x), 32'd0);
        txt = {$urandom, $urandom, $urandom, $urandom};
        run_draw(txt, 0, 1281, 1'b0, 0, 1'b0, 1'b1);
        dpt = 1'b0;
        @(posedge clk); #1;
        check("ddpt_drop4", 32'(ddpt), 32'd0);
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/plaintext_drawer.md
Name: plaintext_drawer

Overview:
- Responder end of the display handshake (dpt/ddpt) driven by the codebreaker state machine.
- On a draw request, latches the 128-bit plaintext and renders its 16 characters as 8x8 glyphs. Glyph rows come from an external synchronous font ROM, and each pixel goes out as a write to the bitmap/VGA writer.
- When the last pixel has been accepted, raises ddpt so the codebreaker can move to its end state.

Parameters:
- X0, 9'd32, x pixel coordinate of the left edge of character 0.
- Y0, 8'd100, y pixel coordinate of the top row of all characters.
- FG, 1'b1, colour value written for a set font bit; a clear bit writes ~FG.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- dpt  in  1  draw request, level; held high by the requester until ddpt is seen.
- plaintext  in  128  text to draw; [127:120] is character 0 (leftmost), [7:0] is character 15.
- ddpt  out  1  draw done; high in DONE state.
- font_addr  out  11  {char_code[7:0], row[2:0]} to the font ROM.
- font_data  in  8  glyph row, valid the cycle after font_addr is presented; bit 7 is the leftmost pixel.
- wr_en  out  1  pixel write valid.
- wr_ready  in  1  bitmap writer accepts; a transfer occurs when wr_en && wr_ready.
- wr_x  out  9  pixel x.
- wr_y  out  8  pixel y.
- wr_color  out  1  pixel colour.

Behaviour:
- Reset (async, reset_n=0):
  - State=IDLE.
  - ddpt=0, wr_en=0, wr_x=0, wr_y=0, wr_color=0, font_addr=0.
  - Character index, row and column counters=0.
  - Takes effect immediately, including mid-draw; no partial-draw resume after reset.
- States: IDLE, FETCH, LOAD, PIXEL, DONE.
- IDLE:
  - dpt=1 at an edge: latch plaintext into an internal register, clear char_idx/row/col, go to FETCH.
  - dpt=0: stay.
- FETCH (1 cycle):
  - font_addr = {text_reg[127-8*char_idx -: 8], row}.
  - Go to LOAD.
- LOAD (1 cycle):
  - Capture font_data into an 8-bit shift register.
  - Go to PIXEL with col=0.
- PIXEL:
  - wr_en=1.
  - wr_x = X0 + 8*char_idx + col, 9-bit, wraps modulo 512 with no error.
  - wr_y = Y0 + row, 8-bit, wraps modulo 256.
  - wr_color = shift_reg[7] ? FG : ~FG.
  - Outputs are registered and stay stable while wr_ready=0.
  - On transfer: shift left, col++.
  - On transfer at col=7: if row<7, row++ and go to FETCH; else row=0 and char_idx++.
  - On transfer at col=7, row=7, char_idx=15: go to DONE.
  - wr_en drops the cycle after the final transfer.
- DONE:
  - ddpt=1.
  - dpt=0 at an edge: go to IDLE, ddpt=0 next cycle.
  - dpt=1: remain in DONE with ddpt held high (four-phase handshake).
- Ordering: character-major, then row, then column. 16x8x8 = 1024 pixel writes per request, exactly once each.
- Latency with wr_ready tied high:
  - 10 cycles per glyph row (FETCH + LOAD + 8 PIXEL); 1280 cycles total.
  - ddpt first observed high 1281 edges after the edge that sampled dpt=1.
- wr_ready low stalls only PIXEL. FETCH and LOAD never stall.
- dpt dropping mid-draw is ignored: the draw completes, DONE is entered, and DONE exits to IDLE at the next edge (ddpt high for exactly 1 cycle).
- plaintext changing during a draw has no effect (latched copy is used). A new request is accepted only from IDLE.
- No character filtering: any byte value indexes the ROM directly.

Test Plan:
- Reset, dpt=1, plaintext = 16 x 8'h41 ("A"), wr_ready=1, ROM model returns row index pattern 8'hF0 -> exactly 1024 writes. First write is x=32, y=100, colour 1. Write #5 is x=36, colour 0. Last write is x=159, y=107. ddpt rises 1281 edges after the dpt edge.
- Same stimulus with wr_ready toggling 1,0,1,0 -> still 1024 writes, same x/y/colour sequence. wr_x/wr_y/wr_color hold while wr_ready=0. Completion extends by 1024 cycles.
- Check font_addr: plaintext[127:120]=8'h5A, [119:112]=8'h20 -> font_addr sequence 0x2D0..0x2D7, then 0x100..0x107.
- Hold dpt high after ddpt -> ddpt stays 1, no further writes. Drop dpt -> ddpt=0 the next cycle. Raise dpt again -> a new draw starts with the freshly latched plaintext.
- Drop dpt after 200 writes -> draw still completes all 1024 writes. ddpt high for exactly 1 cycle, then IDLE.
- Assert reset_n=0 asynchronously after 500 writes -> wr_en and ddpt go 0 immediately without waiting for clk. After release with dpt=1, the draw restarts at x=32, y=100.
